// File: rtl/core_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package core_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Bit width needed to index n items (never less than 1).
    function automatic int unsigned clog2w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push/pop/flush; flush wins over push and pop.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = clog2w(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  fetch_entry_t  i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output fetch_entry_t  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int unsigned PW = clog2w(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_pop;

    assign w_do_pop = i_pop & ~o_empty;
    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && !i_flush && o_full && !w_do_pop));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetcher: credit-limited in-order fetch, response buffering, redirect flush.
module fetch_prefetch_unit
    import core_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pc_src,
    input  logic [31:0] i_pc_target,
    input  logic        i_stall_d,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_4,
    output logic        o_instr_valid,
    output logic [31:0] o_pco_out
);

    localparam int unsigned CW = clog2w(DEPTH + 1);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] w_inflight_d;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_credit_used;
    logic          w_full;
    logic          w_empty;
    logic          w_xfer;
    logic          w_push;
    logic          w_pop;
    logic          w_drop_hit;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;

    // Outstanding requests plus buffered words may never exceed the FIFO depth.
    assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_count};
    assign o_imem_req    = i_rst_n & ~i_pc_src & (w_credit_used < (CW + 1)'(DEPTH));
    assign o_imem_addr   = r_fetch_pc;
    assign o_pco_out     = r_fetch_pc;

    assign w_xfer       = o_imem_req & i_imem_gnt;
    assign w_drop_hit   = i_imem_rvalid & (r_drop_cnt != '0);
    assign w_push       = i_imem_rvalid & (r_drop_cnt == '0) & ~i_pc_src;
    assign w_push_data  = '{instr: i_imem_rdata, pc: r_resp_pc};
    assign w_inflight_d = r_inflight + CW'(w_xfer) - CW'(i_imem_rvalid);

    assign o_instr_valid = ~w_empty & ~i_pc_src;
    assign w_pop         = o_instr_valid & ~i_stall_d;
    assign o_instr       = o_instr_valid ? w_head.instr : NOP_INSTR;
    assign o_pc          = o_instr_valid ? w_head.pc : 32'h0;
    assign o_pc_4        = o_instr_valid ? (w_head.pc + 32'd4) : 32'h0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_inflight <= w_inflight_d;
            if (i_pc_src) begin
                // Everything still outstanding after this edge belongs to the old path.
                r_fetch_pc <= i_pc_target;
                r_resp_pc  <= i_pc_target;
                r_drop_cnt <= w_inflight_d;
            end else begin
                if (w_xfer) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) r_resp_pc <= r_resp_pc + 32'd4;
                if (w_drop_hit) r_drop_cnt <= r_drop_cnt - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (i_pc_src),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    a_drop_le_inflight: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_drop_cnt <= r_inflight);
    a_credit_ok: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(w_push && w_full && !w_pop && !i_pc_src));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an in-order 1-cycle-latency memory model.
module tb_fetch_prefetch_unit;

    localparam logic [31:0] DOFS = 32'h1000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        stall_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic        instr_valid;
    logic [31:0] pco_out;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_gnt = 0;
    int          n_del = 0;
    logic        auto_chk = 1'b0;
    logic        mem_hold = 1'b0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] a0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    fetch_prefetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pc_src      (pc_src),
        .i_pc_target   (pc_target),
        .i_stall_d     (stall_d),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (imem_gnt),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .o_instr       (instr),
        .o_pc          (pc),
        .o_pc_4        (pc_4),
        .o_instr_valid (instr_valid),
        .o_pco_out     (pco_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample at negedge, drive memory response just after posedge.
    task automatic tick();
        logic        xfer;
        logic [31:0] a;
        @(negedge clk);
        xfer = imem_req & imem_gnt;
        a    = imem_addr;
        if (xfer) n_gnt++;
        if (auto_chk && instr_valid && !stall_d) begin
            check_eq("deliver_pc", pc, exp_pc);
            check_eq("deliver_instr", instr, exp_pc + DOFS);
            check_eq("deliver_pc4", pc_4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            n_del++;
        end
        if (pc_src) exp_pc = pc_target;
        @(posedge clk);
        #1;
        if (xfer) q.push_back(a);
        if (!mem_hold && q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = q.pop_front() + DOFS;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        auto_chk    = 1'b0;
        mem_hold    = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!instr_valid && k < 12) begin
            tick();
            k++;
        end
        if (!instr_valid) check_eq(tag, 32'(instr_valid), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        pc_src      = 1'b0;
        pc_target   = 32'h0;
        stall_d     = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        rst_n       = 1'b0;
        #3;
        check_eq("rst_req", 32'(imem_req), 32'h0);
        check_eq("rst_valid", 32'(instr_valid), 32'h0);
        check_eq("rst_instr", instr, NOP);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_pc4", pc_4, 32'h0);
        check_eq("rst_pco", pco_out, 32'h0);

        // Streaming: first valid two cycles after first grant, then one per cycle.
        imem_gnt = 1'b1;
        do_reset();
        check_eq("s_req0", 32'(imem_req), 32'h1);
        check_eq("s_addr0", imem_addr, 32'h0);
        tick();
        check_eq("s_addr1", imem_addr, 32'h4);
        check_eq("s_valid_n1", 32'(instr_valid), 32'h0);
        tick();
        check_eq("s_valid_n2", 32'(instr_valid), 32'h1);
        check_eq("s_pc_first", pc, 32'h0);
        check_eq("s_pc4_first", pc_4, 32'h4);
        check_eq("s_addr2", imem_addr, 32'h8);
        exp_pc   = 32'h0;
        auto_chk = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("thru_valid", 32'(instr_valid), 32'h1);
        end

        // Decode stall: exactly DEPTH grants then fetch stops.
        stall_d = 1'b1;
        do_reset();
        n_gnt = 0;
        repeat (10) tick();
        check_eq("stall_grants", 32'(n_gnt), 32'd4);
        check_eq("stall_req", 32'(imem_req), 32'h0);
        check_eq("stall_head", pc, 32'h0);
        check_eq("stall_addr", imem_addr, 32'h10);
        stall_d  = 1'b0;
        exp_pc   = 32'h0;
        auto_chk = 1'b1;
        n_del    = 0;
        repeat (12) tick();
        check_eq("stall_drain_cnt", 32'(n_del >= 8), 32'h1);

        // Redirect with 2 requests in flight and 2 buffered words.
        stall_d = 1'b1;
        do_reset();
        tick();
        tick();
        mem_hold = 1'b1;
        tick();
        tick();
        check_eq("rd_full_req", 32'(imem_req), 32'h0);
        check_eq("rd_head", pc, 32'h0);
        pc_src    = 1'b1;
        pc_target = 32'h100;
        stall_d   = 1'b0;
        mem_hold  = 1'b0;
        auto_chk  = 1'b1;
        #1;
        check_eq("rd_valid_low", 32'(instr_valid), 32'h0);
        check_eq("rd_req_low", 32'(imem_req), 32'h0);
        tick();
        pc_src = 1'b0;
        #1;
        check_eq("rd_new_addr", imem_addr, 32'h100);
        wait_valid("rd_wait");
        check_eq("rd_pc", pc, 32'h100);
        check_eq("rd_pc4", pc_4, 32'h104);
        check_eq("rd_instr", instr, 32'h100 + DOFS);
        repeat (3) tick();

        // Grant withheld: request and address held steady.
        imem_gnt = 1'b0;
        a0       = imem_addr;
        for (int i = 0; i < 5; i++) begin
            check_eq("ng_req", 32'(imem_req), 32'h1);
            check_eq("ng_addr", imem_addr, a0);
            tick();
        end
        check_eq("ng_drained", 32'(instr_valid), 32'h0);
        imem_gnt = 1'b1;
        tick();
        check_eq("ng_progress", imem_addr, a0 + 32'd4);
        repeat (4) tick();

        // Redirect colliding with a response and a pop, then a second redirect.
        check_eq("co_rvalid", 32'(imem_rvalid), 32'h1);
        check_eq("co_valid_pre", 32'(instr_valid), 32'h1);
        pc_src    = 1'b1;
        pc_target = 32'h180;
        #1;
        check_eq("co_valid_low", 32'(instr_valid), 32'h0);
        tick();
        pc_src = 1'b0;
        tick();
        pc_src    = 1'b1;
        pc_target = 32'h200;
        tick();
        pc_src = 1'b0;
        wait_valid("co_wait");
        check_eq("co_pc", pc, 32'h200);
        check_eq("co_instr", instr, 32'h200 + DOFS);
        repeat (3) tick();

        // Asynchronous reset between edges.
        #1;
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        auto_chk    = 1'b0;
        q.delete();
        #1;
        check_eq("ar_req", 32'(imem_req), 32'h0);
        check_eq("ar_valid", 32'(instr_valid), 32'h0);
        check_eq("ar_instr", instr, NOP);
        check_eq("ar_pc", pc, 32'h0);
        check_eq("ar_pc4", pc_4, 32'h0);
        check_eq("ar_pco", pco_out, 32'h0);
        do_reset();
        check_eq("ar_restart_addr", imem_addr, 32'h0);
        check_eq("ar_restart_req", 32'(imem_req), 32'h1);
        exp_pc   = 32'h0;
        auto_chk = 1'b1;
        n_del    = 0;
        repeat (8) tick();
        check_eq("ar_deliveries", 32'(n_del), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
